// File: rtl/wb_regfile_pkg.sv
// Shared core package: datapath width, register count and the RV32I load
// funct3 encodings used by the writeback stage and the pipeline registers.
package wb_regfile_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned REGW = $clog2(NREG);

    // RV32I load funct3 encodings; 011, 110 and 111 are unused and read as LW.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

endpackage

// File: rtl/wb_regfile_load_formatter.sv
// load_formatter: purely combinational load-data formatter.
//   word     - raw aligned memory word
//   funct3   - RV32I load type
//   byte_off - load address bits [1:0]
//   value    - sign/zero-extended load result
// Halfword loads use byte_off[1] only; misalignment is not trapped here.
module load_formatter
    import wb_regfile_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      value = {{24{byte_sel[7]}}, byte_sel};
            LH:      value = {{16{half_sel[15]}}, half_sel};
            LBU:     value = {24'd0, byte_sel};
            LHU:     value = {16'd0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage with the integer register file and the
// retired-instruction counter.
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   en              - stage enable; 0 stalls (no writes, no retire, no bypass)
//   wb_data_in      - ALU result or raw memory word
//   wb_sel          - 1 selects formatted load data, 0 the ALU result
//   reg_we, rd      - register write request and destination
//   load_funct3     - load type; byte_off - load address bits [1:0]
//   retire_valid    - an instruction retires this cycle
//   rs1/rs2_addr    - read indices; rs1/rs2_data - combinational read data
//   wb_value        - formatted value presented for write this cycle
//   instret         - 64-bit retired-instruction counter
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] wb_data_in,
    input  logic            wb_sel,
    input  logic            reg_we,
    input  logic [REGW-1:0] rd,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      byte_off,
    input  logic            retire_valid,
    input  logic [REGW-1:0] rs1_addr,
    input  logic [REGW-1:0] rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_value,
    output logic [63:0]     instret
);

    logic [XLEN-1:0] regs [NREG];
    logic [63:0]     instret_q;
    logic [XLEN-1:0] load_value;
    logic            wr_active;

    load_formatter u_fmt (
        .word     (wb_data_in),
        .funct3   (load_funct3),
        .byte_off (byte_off),
        .value    (load_value)
    );

    assign wb_value  = wb_sel ? load_value : wb_data_in;
    assign wr_active = en && reg_we && (rd != '0);
    assign instret   = instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            instret_q <= '0;
        end else if (en) begin
            if (wr_active) begin
                regs[rd] <= wb_value;
            end
            if (retire_valid) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // x0 is forced to zero on read; the bypass never triggers for rd=0.
    always_comb begin
        if (rs1_addr == '0)
            rs1_data = '0;
        else if (wr_active && (rs1_addr == rd))
            rs1_data = wb_value;
        else
            rs1_data = regs[rs1_addr];

        if (rs2_addr == '0)
            rs2_data = '0;
        else if (wr_active && (rs2_addr == rd))
            rs2_data = wb_value;
        else
            rs2_data = regs[rs2_addr];
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: expected values are queued when the
// stimulus is applied and compared against the selected output once it settles.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] wb_data_in;
    logic        wb_sel;
    logic        reg_we;
    logic [4:0]  rd;
    logic [2:0]  load_funct3;
    logic [1:0]  byte_off;
    logic        retire_valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_value;
    logic [63:0] instret;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wb_data_in   (wb_data_in),
        .wb_sel       (wb_sel),
        .reg_we       (reg_we),
        .rd           (rd),
        .load_funct3  (load_funct3),
        .byte_off     (byte_off),
        .retire_valid (retire_valid),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_value     (wb_value),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef enum {SRC_RS1, SRC_RS2, SRC_WBV, SRC_INSTRET} src_e;
    typedef struct {
        string       tag;
        src_e        src;
        logic [63:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_instret = 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input src_e src, input logic [63:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [63:0] got;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.src)
                SRC_RS1:     got = {32'd0, rs1_data};
                SRC_RS2:     got = {32'd0, rs2_data};
                SRC_WBV:     got = {32'd0, wb_value};
                default:     got = instret;
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && en && retire_valid) exp_instret = exp_instret + 64'd1;
        if (rst) exp_instret = 64'd0;
        #1;
    endtask

    // word 0x80FF_7F01: bytes 01, 7F, FF, 80 from offset 0 upward
    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } fmt_vec_t;

    fmt_vec_t fmt_tab[14] = '{
        '{3'b000, 2'd3, 32'hFFFF_FF80},
        '{3'b100, 2'd1, 32'h0000_007F},
        '{3'b001, 2'd2, 32'hFFFF_80FF},
        '{3'b101, 2'd0, 32'h0000_7F01},
        '{3'b010, 2'd1, 32'h80FF_7F01},
        '{3'b011, 2'd0, 32'h80FF_7F01},
        '{3'b110, 2'd2, 32'h80FF_7F01},
        '{3'b111, 2'd3, 32'h80FF_7F01},
        '{3'b000, 2'd1, 32'h0000_007F},
        '{3'b100, 2'd3, 32'h0000_0080},
        '{3'b001, 2'd3, 32'hFFFF_80FF},
        '{3'b101, 2'd1, 32'h0000_7F01},
        '{3'b001, 2'd0, 32'h0000_7F01},
        '{3'b101, 2'd2, 32'h0000_80FF}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; wb_data_in = '0; wb_sel = 1'b0; reg_we = 1'b0;
        rd = '0; load_funct3 = 3'b010; byte_off = '0; retire_valid = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd7;

        // reset state
        tick();
        rst = 1'b0;
        expect_val("reset_x5", SRC_RS1, 64'd0);
        expect_val("reset_x7", SRC_RS2, 64'd0);
        expect_val("reset_instret", SRC_INSTRET, 64'd0);
        drain();

        // basic ALU write, read back next cycle
        reg_we = 1'b1; rd = 5'd5; wb_data_in = 32'h1234_5678; rs1_addr = 5'd0; rs2_addr = 5'd0;
        expect_val("alu_wbv", SRC_WBV, 64'h1234_5678);
        drain();
        tick();
        reg_we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
        expect_val("x5_read", SRC_RS1, 64'h1234_5678);
        expect_val("x0_read", SRC_RS2, 64'd0);
        drain();

        // load formatting
        wb_sel = 1'b1; wb_data_in = 32'h80FF_7F01;
        for (int i = 0; i < 14; i++) begin
            load_funct3 = fmt_tab[i].f3;
            byte_off    = fmt_tab[i].off;
            expect_val($sformatf("fmt_f3_%0d_off_%0d", fmt_tab[i].f3, fmt_tab[i].off),
                       SRC_WBV, {32'd0, fmt_tab[i].exp});
            drain();
        end

        // formatted load reaches the register file
        load_funct3 = 3'b000; byte_off = 2'd3; reg_we = 1'b1; rd = 5'd9;
        tick();
        reg_we = 1'b0; wb_sel = 1'b0; rs1_addr = 5'd9;
        expect_val("x9_lb", SRC_RS1, 64'hFFFF_FF80);
        drain();

        // x0 write is discarded and not bypassed
        reg_we = 1'b1; rd = 5'd0; wb_data_in = 32'hDEAD_BEEF; rs1_addr = 5'd0; rs2_addr = 5'd0;
        expect_val("x0_wbv", SRC_WBV, 64'hDEAD_BEEF);
        expect_val("x0_nobyp1", SRC_RS1, 64'd0);
        expect_val("x0_nobyp2", SRC_RS2, 64'd0);
        drain();
        tick();
        reg_we = 1'b0;
        expect_val("x0_after", SRC_RS1, 64'd0);
        drain();

        // dual-port bypass and stall
        reg_we = 1'b1; rd = 5'd7; wb_data_in = 32'h1111_1111;
        tick();
        wb_data_in = 32'h2222_2222; rs1_addr = 5'd7; rs2_addr = 5'd7;
        expect_val("byp_rs1", SRC_RS1, 64'h2222_2222);
        expect_val("byp_rs2", SRC_RS2, 64'h2222_2222);
        drain();
        tick();
        reg_we = 1'b0;
        expect_val("x7_written", SRC_RS1, 64'h2222_2222);
        drain();
        en = 1'b0; reg_we = 1'b1; wb_data_in = 32'h3333_3333; retire_valid = 1'b1;
        expect_val("stall_rs1", SRC_RS1, 64'h2222_2222);
        expect_val("stall_rs2", SRC_RS2, 64'h2222_2222);
        drain();
        tick();
        en = 1'b1; reg_we = 1'b0; retire_valid = 1'b0;
        expect_val("stall_x7", SRC_RS1, 64'h2222_2222);
        expect_val("stall_instret", SRC_INSTRET, 64'd0);
        drain();

        // instret counting
        retire_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        retire_valid = 1'b0;
        expect_val("instret_3", SRC_INSTRET, exp_instret);
        drain();

        // wrap from all-ones
        en = 1'b0;
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        expect_val("instret_preload", SRC_INSTRET, exp_instret);
        drain();
        en = 1'b1; retire_valid = 1'b1;
        tick();
        expect_val("instret_max", SRC_INSTRET, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        tick();
        expect_val("instret_wrap", SRC_INSTRET, 64'd0);
        drain();
        en = 1'b0;
        tick();
        expect_val("instret_stalled", SRC_INSTRET, 64'd0);
        drain();
        en = 1'b1; retire_valid = 1'b0;

        // reset wins over coincident write and retire
        reg_we = 1'b1; rd = 5'd3; wb_data_in = 32'h0000_AAAA; retire_valid = 1'b1;
        tick();
        rs1_addr = 5'd3; rs2_addr = 5'd5; reg_we = 1'b0; retire_valid = 1'b0;
        expect_val("x3_pre", SRC_RS1, 64'h0000_AAAA);
        expect_val("instret_pre", SRC_INSTRET, 64'd1);
        drain();
        rst = 1'b1; reg_we = 1'b1; wb_data_in = 32'h0000_0055; retire_valid = 1'b1;
        expect_val("rst_wbv", SRC_WBV, 64'h0000_0055);
        drain();
        tick();
        rst = 1'b0; reg_we = 1'b0; retire_valid = 1'b0;
        expect_val("rst_x3", SRC_RS1, 64'd0);
        expect_val("rst_x5", SRC_RS2, 64'd0);
        expect_val("rst_instret", SRC_INSTRET, 64'd0);
        drain();

        // first write after reset is accepted
        reg_we = 1'b1; rd = 5'd3; wb_data_in = 32'h0000_0077;
        tick();
        reg_we = 1'b0;
        expect_val("post_rst_x3", SRC_RS1, 64'h0000_0077);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
